fpga_config_loader: RTL and testbench

Configuration controller that sits directly upstream of the `FPGA` fabric model. It accepts a 42-word configuration stream over a valid/ready handshake and writes each word into the matching register bank: 11 LUT truth tables, 20 switch-box `configure` words and 11 LUT flop-select bits. It then drives the resulting banks as flat buses into the fabric. While loading, it holds the fabric's sequential elements; once the full stream has landed, it releases them with `done`.

---
 rtl/fpga_config_loader.sv | 120 ++++++++++++
 tb/tb_fpga_config_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fpga_config_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpga_config_loader: streams 42 config words into LUT/switch-box banks    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fpga_config_loader #(
  parameter int NUM_LUT = 11,
  parameter int NUM_SB  = 20,
  parameter int WORD_W  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WORD_W-1:0]        cfg_data,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic [NUM_LUT*32-1:0]    lut_tt,
  output logic [NUM_LUT-1:0]       lut_sel,
  output logic [NUM_SB*WORD_W-1:0] sb_cfg,
  output logic                     fabric_hold,
  output logic                     done,
  output logic [5:0]               word_idx
);

  localparam int c_num_words = 2 * NUM_LUT + NUM_SB;
  localparam int c_first_sb  = NUM_LUT;
  localparam int c_first_sel = NUM_LUT + NUM_SB;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_LUT = 3'd1,
    LOAD_SB  = 3'd2,
    LOAD_SEL = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [5:0]                word_idx_q, word_idx_d;
  logic [NUM_LUT*32-1:0]     lut_tt_q, lut_tt_d;
  logic [NUM_LUT-1:0]        lut_sel_q, lut_sel_d;
  logic [NUM_SB*WORD_W-1:0]  sb_cfg_q, sb_cfg_d;
  logic                      w_accept;

  // Ready is a pure decode of registered state so it never combinationally
  // depends on cfg_valid.
  assign cfg_ready   = (state_q == LOAD_LUT) || (state_q == LOAD_SB) || (state_q == LOAD_SEL);
  assign w_accept    = cfg_ready && cfg_valid;
  assign done        = (state_q == DONE);
  assign fabric_hold = (state_q != DONE);
  assign lut_tt      = lut_tt_q;
  assign lut_sel     = lut_sel_q;
  assign sb_cfg      = sb_cfg_q;
  assign word_idx    = word_idx_q;

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    lut_tt_d   = lut_tt_q;
    lut_sel_d  = lut_sel_q;
    sb_cfg_d   = sb_cfg_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD_LUT;
          word_idx_d = 6'd0;
        end
      end
      LOAD_LUT: begin
        if (w_accept) begin
          for (int i = 0; i < NUM_LUT; i++) begin
            if (word_idx_q == 6'(i)) lut_tt_d[i*32 +: 32] = cfg_data[31:0];
          end
          word_idx_d = word_idx_q + 6'd1;
          if (word_idx_q == 6'(c_first_sb - 1)) state_d = LOAD_SB;
        end
      end
      LOAD_SB: begin
        if (w_accept) begin
          for (int j = 0; j < NUM_SB; j++) begin
            if (word_idx_q == 6'(c_first_sb + j)) sb_cfg_d[j*WORD_W +: WORD_W] = cfg_data;
          end
          word_idx_d = word_idx_q + 6'd1;
          if (word_idx_q == 6'(c_first_sel - 1)) state_d = LOAD_SEL;
        end
      end
      LOAD_SEL: begin
        if (w_accept) begin
          // Only the flop-select bit of these words is meaningful.
          for (int k = 0; k < NUM_LUT; k++) begin
            if (word_idx_q == 6'(c_first_sel + k)) lut_sel_d[k] = cfg_data[31];
          end
          word_idx_d = word_idx_q + 6'd1;
          if (word_idx_q == 6'(c_num_words - 1)) state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      word_idx_q <= 6'd0;
      lut_tt_q   <= '0;
      lut_sel_q  <= '0;
      sb_cfg_q   <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      lut_tt_q   <= lut_tt_d;
      lut_sel_q  <= lut_sel_d;
      sb_cfg_q   <= sb_cfg_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpga_config_loader.sv
`default_nettype none
// Directed testbench for fpga_config_loader.
module tb_fpga_config_loader;

  localparam int NUM_LUT = 11;
  localparam int NUM_SB  = 20;
  localparam int WORD_W  = 32;

  logic                     clk = 1'b0;
  logic                     reset, start, cfg_valid;
  logic [WORD_W-1:0]        cfg_data;
  logic                     cfg_ready, fabric_hold, done;
  logic [NUM_LUT*32-1:0]    lut_tt;
  logic [NUM_LUT-1:0]       lut_sel;
  logic [NUM_SB*WORD_W-1:0] sb_cfg;
  logic [5:0]               word_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpga_config_loader #(.NUM_LUT(NUM_LUT), .NUM_SB(NUM_SB), .WORD_W(WORD_W)) dut (
    .clock(clk), .reset(reset), .start(start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .lut_tt(lut_tt),
    .lut_sel(lut_sel), .sb_cfg(sb_cfg), .fabric_hold(fabric_hold),
    .done(done), .word_idx(word_idx)
  );

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [639:0] lut_model(input logic [31:0] base);
    logic [639:0] r = '0;
    for (int i = 0; i < NUM_LUT; i++) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction

  function automatic logic [639:0] sb_model(input logic [31:0] base);
    logic [639:0] r = '0;
    for (int j = 0; j < NUM_SB; j++) r[j*32 +: 32] = base + 32'(NUM_LUT + j);
    return r;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Send words first..last of stream base; gaps idle cycles precede each word after the first.
  task automatic send_words(input logic [31:0] base, input int first, input int last, input int gaps,
                            input bit chk_idx);
    for (int n = first; n <= last; n++) begin
      if (n != first) begin
        for (int g = 0; g < gaps; g++) begin
          cfg_valid = 1'b0;
          cfg_data  = 32'hDEAD_BEEF;
          tick();
          if (chk_idx) check("bubble_idx_stall", 640'(word_idx), 640'(n));
        end
      end
      cfg_valid = 1'b1;
      cfg_data  = base + 32'(n);
      tick();
      if (chk_idx) check("accept_idx", 640'(word_idx), 640'(n + 1));
    end
    cfg_valid = 1'b0;
  endtask

  task automatic check_full(input string tag, input logic [31:0] base);
    check({tag, "_lut_tt"}, 640'(lut_tt), lut_model(base));
    check({tag, "_sb_cfg"}, 640'(sb_cfg), sb_model(base));
    check({tag, "_lut_sel"}, 640'(lut_sel), 640'(11'h7FF));
    check({tag, "_done"}, 640'(done), 640'(1));
    check({tag, "_hold"}, 640'(fabric_hold), 640'(0));
    check({tag, "_idx"}, 640'(word_idx), 640'(42));
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; cfg_valid = 1'b1; cfg_data = 32'hFFFF_FFFF;
    tick(); tick();
    check("rst_lut_tt", 640'(lut_tt), 640'(0));
    check("rst_sb_cfg", 640'(sb_cfg), 640'(0));
    check("rst_lut_sel", 640'(lut_sel), 640'(0));
    check("rst_ready", 640'(cfg_ready), 640'(0));
    check("rst_done", 640'(done), 640'(0));
    check("rst_hold", 640'(fabric_hold), 640'(1));
    check("rst_idx", 640'(word_idx), 640'(0));
    reset = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    tick();
    check("idle_ready", 640'(cfg_ready), 640'(0));

    // Back-to-back load: done must rise on the 42nd edge after start.
    pulse_start();
    check("start_ready", 640'(cfg_ready), 640'(1));
    check("start_idx", 640'(word_idx), 640'(0));
    send_words(32'hA000_0000, 0, 40, 0, 1'b0);
    check("b2b_done_early", 640'(done), 640'(0));
    check("b2b_hold_early", 640'(fabric_hold), 640'(1));
    send_words(32'hA000_0000, 41, 41, 0, 1'b0);
    check("b2b_lut3", 640'(lut_tt[3*32 +: 32]), 640'(32'hA000_0003));
    check("b2b_sb0", 640'(sb_cfg[0 +: 32]), 640'(32'hA000_000B));
    check("b2b_sb19", 640'(sb_cfg[19*32 +: 32]), 640'(32'hA000_001E));
    check_full("b2b", 32'hA000_0000);

    // DONE ignores the stream.
    cfg_valid = 1'b1; cfg_data = 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) tick();
    cfg_valid = 1'b0;
    check("donein_ready", 640'(cfg_ready), 640'(0));
    check_full("donein", 32'hA000_0000);

    // Reset, then a bubbly load of the same stream.
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst2_lut_tt", 640'(lut_tt), 640'(0));
    pulse_start();
    send_words(32'hA000_0000, 0, 41, 2, 1'b1);
    check_full("bub", 32'hA000_0000);

    // Start mid-load is ignored; reset mid-load clears everything.
    pulse_start();
    send_words(32'h5000_0000, 0, 19, 0, 1'b0);
    pulse_start();
    check("ign_start_idx", 640'(word_idx), 640'(20));
    check("ign_start_ready", 640'(cfg_ready), 640'(1));
    send_words(32'h5000_0000, 20, 24, 0, 1'b0);
    check("mid_idx", 640'(word_idx), 640'(25));
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_lut_tt", 640'(lut_tt), 640'(0));
    check("midrst_sb_cfg", 640'(sb_cfg), 640'(0));
    check("midrst_lut_sel", 640'(lut_sel), 640'(0));
    check("midrst_ready", 640'(cfg_ready), 640'(0));
    check("midrst_idx", 640'(word_idx), 640'(0));
    pulse_start();
    send_words(32'hB000_0000, 0, 41, 0, 1'b0);
    check_full("after_rst", 32'hB000_0000);

    // Reconfigure only the LUT truth tables.
    pulse_start();
    check("recfg_done_drop", 640'(done), 640'(0));
    send_words(32'hC000_0000, 0, 10, 0, 1'b0);
    check("recfg_done", 640'(done), 640'(0));
    check("recfg_hold", 640'(fabric_hold), 640'(1));
    check("recfg_idx", 640'(word_idx), 640'(11));
    check("recfg_lut_tt", 640'(lut_tt), lut_model(32'hC000_0000));
    check("recfg_lut5", 640'(lut_tt[5*32 +: 32]), 640'(32'hC000_0005));
    check("recfg_sb_cfg", 640'(sb_cfg), sb_model(32'hB000_0000));
    check("recfg_lut_sel", 640'(lut_sel), 640'(11'h7FF));

    // A selector stream with bit 31 clear in alternate words.
    send_words(32'hD000_0000, 11, 30, 0, 1'b0);
    for (int n = 31; n <= 41; n++) begin
      cfg_valid = 1'b1;
      cfg_data  = (n % 2 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      tick();
    end
    cfg_valid = 1'b0;
    check("sel_pattern", 640'(lut_sel), 640'(11'b01010101010));
    check("sel_done", 640'(done), 640'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
